// File: rtl/button_stepper_pkg.sv
// button_stepper shared definitions.
// Default timing constants and the hold FSM state type.
package button_stepper_pkg;

  // 10 ms debounce, 500 ms first repeat, 100 ms repeat period at 10 MHz
  localparam int DEF_DB_CYCLES  = 100000;
  localparam int DEF_RPT_DELAY  = 5000000;
  localparam int DEF_RPT_PERIOD = 1000000;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    HELD_DELAY  = 2'd1,
    HELD_REPEAT = 2'd2
  } state_t;

  // Bits needed to hold values up to max(a,b)-1, never below 1.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/debounce.sv
// Push-button synchronizer and debounce filter.
// dout follows din only after din stays different for DB_CYCLES cycles.
module debounce
  import button_stepper_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CW = cnt_width(DB_CYCLES, 1);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic          s1;
  logic          btn_s;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer for the asynchronous button level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1    <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      s1    <= din;
      btn_s <= s1;
    end
  end

  // Stability counter; output flips once the new level has persisted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (btn_s == dout) begin
      cnt  <= '0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      dout <= ~dout;
    end else begin
      cnt  <= cnt + ONE;
    end
  end

endmodule

// File: rtl/button_stepper.sv
// Debounced push-button to step strobe with optional auto-repeat.
// One step per press, then repeats after a delay while held and enabled.
module button_stepper
  import button_stepper_pkg::*;
#(
  parameter int DB_CYCLES  = DEF_DB_CYCLES,
  parameter int RPT_DELAY  = DEF_RPT_DELAY,
  parameter int RPT_PERIOD = DEF_RPT_PERIOD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  input  logic       repeat_en,
  output logic       step,
  output logic       pressed,
  output logic [7:0] press_count
);

  localparam int TW = cnt_width(RPT_DELAY, RPT_PERIOD);
  localparam logic [TW-1:0] DLY_LAST = TW'(RPT_DELAY - 1);
  localparam logic [TW-1:0] PER_LAST = TW'(RPT_PERIOD - 1);
  localparam logic [TW-1:0] T_ONE    = TW'(1);

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nxt;
  logic          rpt_q;
  logic          rpt_nxt;
  logic          pressed_d;
  logic          rise;

  debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_db (
    .clk  (clk),
    .reset(reset),
    .din  (btn_raw),
    .dout (pressed)
  );

  // The press step lands in the first cycle pressed reads 1; a
  // repeat strobe is dropped if the button released on that edge.
  assign rise = pressed & ~pressed_d;
  assign step = rise | (rpt_q & pressed);

  // Hold FSM and repeat timer; timer counts cycles since last step
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    rpt_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = HELD_DELAY;
          timer_nxt = repeat_en ? T_ONE : '0;
        end
      end
      HELD_DELAY: begin
        if (!pressed) begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end else if (!repeat_en) begin
          timer_nxt = '0;
        end else if (timer == DLY_LAST) begin
          state_nxt = HELD_REPEAT;
          timer_nxt = '0;
          rpt_nxt   = ~step;
        end else begin
          timer_nxt = timer + T_ONE;
        end
      end
      HELD_REPEAT: begin
        if (!pressed) begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end else if (!repeat_en) begin
          state_nxt = HELD_DELAY;
          timer_nxt = '0;
        end else if (timer == PER_LAST) begin
          timer_nxt = '0;
          rpt_nxt   = ~step;
        end else begin
          timer_nxt = timer + T_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  // State, timer, edge history and step counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      rpt_q       <= 1'b0;
      pressed_d   <= 1'b0;
      press_count <= 8'd0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      rpt_q       <= rpt_nxt;
      pressed_d   <= pressed;
      press_count <= press_count + {7'd0, step};
    end
  end

endmodule

// File: tb/tb_button_stepper.sv
// Self-checking bench for button_stepper.
// Small timing parameters; vector table plus multi-cycle sequences.
module tb_button_stepper;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_raw;
  logic       repeat_en;
  logic       step;
  logic       pressed;
  logic [7:0] press_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int nsteps = 0;
  logic prev_step = 1'b0;

  button_stepper #(
    .DB_CYCLES (DB),
    .RPT_DELAY (RD),
    .RPT_PERIOD(RP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .repeat_en  (repeat_en),
    .step       (step),
    .pressed    (pressed),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       btn;
    logic       ren;
    int         n;
    logic       p;
    logic       s;
    logic [7:0] c;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (step) begin
      nsteps++;
      chk("no_back_to_back_step", int'(prev_step), 0);
    end
    prev_step = step;
  endtask

  task automatic find_press(output int p, output int found);
    found = 0;
    p = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick();
      if (step) found = 1;
    end
    chk("press_step_seen", found, 1);
    p = cyc;
  endtask

  task automatic press();
    btn_raw = 1'b1;
    repeat (8) tick();
    btn_raw = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_cnt;
    int p;
    int found;
    int offs[$];
    int e34[5];
    int e35[3];
    int bad;
    int s0;

    e34 = '{0, 20, 25, 30, 35};
    e35 = '{0, 20, 52};

    tbl[0] = '{1'b1, 1'b0, 5,  1'b0, 1'b0, 8'd0};
    tbl[1] = '{1'b1, 1'b0, 1,  1'b1, 1'b1, 8'd0};
    tbl[2] = '{1'b1, 1'b0, 1,  1'b1, 1'b0, 8'd1};
    tbl[3] = '{1'b1, 1'b0, 40, 1'b1, 1'b0, 8'd1};
    tbl[4] = '{1'b0, 1'b0, 5,  1'b1, 1'b0, 8'd1};
    tbl[5] = '{1'b0, 1'b0, 1,  1'b0, 1'b0, 8'd1};
    tbl[6] = '{1'b1, 1'b1, 3,  1'b0, 1'b0, 8'd1};
    tbl[7] = '{1'b0, 1'b1, 10, 1'b0, 1'b0, 8'd1};

    reset = 1'b1;
    btn_raw = 1'b0;
    repeat_en = 1'b0;
    tick();
    tick();
    chk("reset_pressed", int'(pressed), 0);
    chk("reset_step", int'(step), 0);
    chk("reset_count", int'(press_count), 0);
    reset = 1'b0;
    tick();
    chk("post_reset_step", int'(step), 0);

    // Basic press, long hold without repeat, release, short glitch
    for (int i = 0; i < 8; i++) begin
      btn_raw = tbl[i].btn;
      repeat_en = tbl[i].ren;
      repeat (tbl[i].n) tick();
      chk($sformatf("vec%0d_pressed", i), int'(pressed), int'(tbl[i].p));
      chk($sformatf("vec%0d_step", i), int'(step), int'(tbl[i].s));
      chk($sformatf("vec%0d_count", i), int'(press_count), int'(tbl[i].c));
    end
    exp_cnt = 1;

    // Bouncing input: 3 high, 2 low, ten times
    bad = 0;
    s0 = nsteps;
    repeat_en = 1'b0;
    for (int r = 0; r < 10; r++) begin
      btn_raw = 1'b1;
      repeat (3) begin tick(); if (pressed) bad++; end
      btn_raw = 1'b0;
      repeat (2) begin tick(); if (pressed) bad++; end
    end
    repeat (8) tick();
    chk("bounce_pressed_cycles", bad, 0);
    chk("bounce_steps", nsteps - s0, 0);
    chk("bounce_count", int'(press_count), exp_cnt);

    // Auto-repeat; release timed so the P+40 expiry meets the release
    repeat_en = 1'b1;
    btn_raw = 1'b1;
    find_press(p, found);
    offs.delete();
    offs.push_back(0);
    for (int k = 1; k <= 48; k++) begin
      tick();
      if (step) offs.push_back(cyc - p);
      if (cyc - p == 34) btn_raw = 1'b0;
    end
    chk("rpt_nsteps", offs.size(), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("rpt_step%0d_off", i),
          (i < offs.size()) ? offs[i] : -1, e34[i]);
    exp_cnt += 5;
    chk("rpt_count", int'(press_count), exp_cnt);
    chk("rpt_released", int'(pressed), 0);

    // repeat_en dropped for 10 cycles restarts the full delay
    repeat_en = 1'b1;
    btn_raw = 1'b1;
    find_press(p, found);
    offs.delete();
    offs.push_back(0);
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (step) offs.push_back(cyc - p);
      if (cyc - p == 22) repeat_en = 1'b0;
      if (cyc - p == 32) repeat_en = 1'b1;
      if (cyc - p == 50) btn_raw = 1'b0;
    end
    chk("gate_nsteps", offs.size(), 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("gate_step%0d_off", i),
          (i < offs.size()) ? offs[i] : -1, e35[i]);
    exp_cnt += 3;
    chk("gate_count", int'(press_count), exp_cnt);

    // Count up to 255 with single presses, then wrap
    repeat_en = 1'b0;
    while (exp_cnt != 255) begin
      press();
      exp_cnt++;
    end
    chk("count_255", int'(press_count), 255);
    s0 = nsteps;
    press();
    chk("wrap_steps", nsteps - s0, 1);
    chk("wrap_count", int'(press_count), 0);

    // Reset in the middle of a hold
    repeat_en = 1'b1;
    btn_raw = 1'b1;
    find_press(p, found);
    while (cyc - p < 10) tick();
    chk("prereset_count", int'(press_count), 1);
    reset = 1'b1;
    #1;
    chk("midreset_pressed", int'(pressed), 0);
    chk("midreset_step", int'(step), 0);
    chk("midreset_count", int'(press_count), 0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("reset_release_step", int'(step), 0);
    bad = 0;
    repeat (5) begin
      tick();
      if (step || pressed) bad++;
    end
    chk("rerelease_quiet", bad, 0);
    tick();
    chk("rerelease_pressed", int'(pressed), 1);
    chk("rerelease_step", int'(step), 1);
    tick();
    chk("rerelease_count", int'(press_count), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
